// File: rtl/nsa_pkg.sv
// rtl/nsa_pkg.sv - shared types and constants for the nibble-serial adder
package nsa_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   localparam int NIBBLE = 4;

   function automatic int nib_count(input int width);
      return width / NIBBLE;
   endfunction

endpackage

// File: rtl/nibble_serial_adder_if.sv
// rtl/nibble_serial_adder_if.sv - operand and result handshakes of the nibble-serial adder
interface nibble_serial_adder_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;

   modport master (
      output in_valid, a, b, cin, out_ready,
      input  in_ready, out_valid, sum, cout
   );

   modport slave (
      input  in_valid, a, b, cin, out_ready,
      output in_ready, out_valid, sum, cout
   );
endinterface

// File: rtl/cla4_cin.sv
// rtl/cla4_cin.sv - combinational 4-bit carry-lookahead slice with carry-in
module cla4_cin (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   output logic [3:0] sum,
   output logic       cout
);
   logic [3:0] g;
   logic [3:0] p;
   logic [4:0] c;

   assign g = a & b;
   assign p = a ^ b;

   assign c[0] = cin;
   assign c[1] = g[0] | (p[0] & cin);
   assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
   assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
   assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
               | (p[3] & p[2] & p[1] & p[0] & cin);

   assign sum  = p ^ c[3:0];
   assign cout = c[4];
endmodule

// File: rtl/nibble_serial_adder.sv
// rtl/nibble_serial_adder.sv - WIDTH-bit adder walking one shared CLA slice, LS nibble first
module nibble_serial_adder
   import nsa_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input logic                  clock,
   input logic                  reset_n,
   nibble_serial_adder_if.slave bus
);
   localparam int NUM_NIB = nib_count(WIDTH);
   localparam int IDX_W   = (NUM_NIB > 1) ? $clog2(NUM_NIB) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NIB - 1);

   state_t            state_q, state_d;
   logic [WIDTH-1:0]  a_q, a_d;
   logic [WIDTH-1:0]  b_q, b_d;
   logic [WIDTH-1:0]  sum_q, sum_d;
   logic              carry_q, carry_d;
   logic              cout_q, cout_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [NIBBLE-1:0] nib_a, nib_b, nib_sum;
   logic              nib_cout;

   // Per-nibble decode keeps the select a flat mux independent of WIDTH depth.
   always_comb begin
      nib_a = '0;
      nib_b = '0;
      for (int k = 0; k < NUM_NIB; k++) begin
         if (idx_q == IDX_W'(k)) begin
            nib_a = a_q[k*NIBBLE +: NIBBLE];
            nib_b = b_q[k*NIBBLE +: NIBBLE];
         end
      end
   end

   cla4_cin u_cla (
      .a    (nib_a),
      .b    (nib_b),
      .cin  (carry_q),
      .sum  (nib_sum),
      .cout (nib_cout)
   );

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      idx_d   = idx_q;
      unique case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               a_d     = bus.a;
               b_d     = bus.b;
               carry_d = bus.cin;
               sum_d   = '0;
               cout_d  = 1'b0;
               idx_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            for (int k = 0; k < NUM_NIB; k++) begin
               if (idx_q == IDX_W'(k)) begin
                  sum_d[k*NIBBLE +: NIBBLE] = nib_sum;
               end
            end
            carry_d = nib_cout;
            if (idx_q == LAST_IDX) begin
               cout_d  = nib_cout;
               idx_d   = '0;
               state_d = DONE;
            end else begin
               idx_d = idx_q + IDX_W'(1);
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
         idx_q   <= idx_d;
      end
   end

   assign bus.in_ready  = (state_q == IDLE);
   assign bus.out_valid = (state_q == DONE);
   assign bus.sum       = sum_q;
   assign bus.cout      = cout_q;
endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb/tb_nibble_serial_adder.sv - self-checking bench for nibble_serial_adder at WIDTH 16 and 8
module tb_nibble_serial_adder;

   logic clock = 1'b0;
   logic reset_n;
   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc   = 0;

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   nibble_serial_adder_if #(.WIDTH(16)) i16 ();
   nibble_serial_adder_if #(.WIDTH(8))  i8 ();

   nibble_serial_adder #(.WIDTH(16)) dut16 (.clock(clock), .reset_n(reset_n), .bus(i16));
   nibble_serial_adder #(.WIDTH(8))  dut8  (.clock(clock), .reset_n(reset_n), .bus(i8));

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic        cin;
      logic [16:0] exp;
   } vec_t;

   vec_t        tbl [8];
   logic [16:0] q16 [$];
   logic [8:0]  q8  [$];

   int t0_16 = 0, t0_8 = 0;
   bit have16 = 0, have8 = 0, sp_chk = 0, pov16 = 0, pov8 = 0;

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
   endfunction

   function automatic void fail_now(input string name);
      n_cmp++;
      n_bad++;
      $display("FAIL %s: event not seen, required within bound", name);
   endfunction

   // Scoreboard/timing monitors, sampled on the falling edge.
   always @(negedge clock) begin
      if (reset_n) begin
         if (i16.in_valid && i16.in_ready) begin
            if (sp_chk && have16) check("accept_spacing16", cyc + 1 - t0_16, 6);
            t0_16  = cyc + 1;
            have16 = 1;
         end
         if (i16.out_valid && !pov16) check("latency16", cyc - t0_16, 4);
         if (i16.out_valid && i16.out_ready) begin
            if (q16.size() == 0) fail_now("expected_result16");
            else check("result16", 32'({i16.cout, i16.sum}), 32'(q16.pop_front()));
         end
         pov16 = i16.out_valid;

         if (i8.in_valid && i8.in_ready) begin
            if (sp_chk && have8) check("accept_spacing8", cyc + 1 - t0_8, 4);
            t0_8  = cyc + 1;
            have8 = 1;
         end
         if (i8.out_valid && !pov8) check("latency8", cyc - t0_8, 2);
         if (i8.out_valid && i8.out_ready) begin
            if (q8.size() == 0) fail_now("expected_result8");
            else check("result8", 32'({i8.cout, i8.sum}), 32'(q8.pop_front()));
         end
         pov8 = i8.out_valid;
      end
   end

   task automatic send16(input logic [15:0] a, input logic [15:0] b, input logic c,
                         input logic [16:0] exp, input bit push);
      int n = 0;
      i16.a = a; i16.b = b; i16.cin = c; i16.in_valid = 1'b1;
      if (push) q16.push_back(exp);
      @(negedge clock);
      while (!i16.in_ready && n < 40) begin @(negedge clock); n++; end
      if (!i16.in_ready) fail_now("accept16");
      @(posedge clock); #1;
      i16.in_valid = 1'b0;
   endtask

   task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic c, input logic [8:0] exp);
      int n = 0;
      i8.a = a; i8.b = b; i8.cin = c; i8.in_valid = 1'b1;
      q8.push_back(exp);
      @(negedge clock);
      while (!i8.in_ready && n < 40) begin @(negedge clock); n++; end
      if (!i8.in_ready) fail_now("accept8");
      @(posedge clock); #1;
      i8.in_valid = 1'b0;
   endtask

   task automatic drain16();
      int n = 0;
      while (q16.size() != 0 && n < 60) begin @(negedge clock); n++; end
      if (q16.size() != 0) begin fail_now("drain16"); q16.delete(); end
      @(posedge clock); #1;
   endtask

   task automatic drain8();
      int n = 0;
      while (q8.size() != 0 && n < 60) begin @(negedge clock); n++; end
      if (q8.size() != 0) begin fail_now("drain8"); q8.delete(); end
      @(posedge clock); #1;
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_in_ready16"},  32'(i16.in_ready),  1);
      check({tag, "_out_valid16"}, 32'(i16.out_valid), 0);
      check({tag, "_sum16"},       32'(i16.sum),       0);
      check({tag, "_cout16"},      32'(i16.cout),      0);
      check({tag, "_in_ready8"},   32'(i8.in_ready),   1);
      check({tag, "_out_valid8"},  32'(i8.out_valid),  0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete, required completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [15:0] ra, rb;
      logic [7:0]  sa, sb;
      logic        rc;
      int          n;

      tbl[0] = '{16'h1234, 16'h4321, 1'b0, 17'h05555};
      tbl[1] = '{16'hFFFF, 16'h0001, 1'b0, 17'h10000};
      tbl[2] = '{16'h00FF, 16'h0000, 1'b1, 17'h00100};
      tbl[3] = '{16'h0000, 16'h0000, 1'b0, 17'h00000};
      tbl[4] = '{16'hFFFF, 16'hFFFF, 1'b1, 17'h1FFFF};
      tbl[5] = '{16'h8000, 16'h8000, 1'b0, 17'h10000};
      tbl[6] = '{16'h0F0F, 16'hF0F0, 1'b1, 17'h10000};
      tbl[7] = '{16'h7FFF, 16'h0001, 1'b0, 17'h08000};

      reset_n = 1'b0;
      i16.in_valid = 1'b0; i16.out_ready = 1'b1; i16.a = '0; i16.b = '0; i16.cin = 1'b0;
      i8.in_valid  = 1'b0; i8.out_ready  = 1'b1; i8.a  = '0; i8.b  = '0; i8.cin  = 1'b0;
      repeat (2) @(negedge clock);
      check_idle("reset");
      @(posedge clock); #1 reset_n = 1'b1;
      @(negedge clock);
      check_idle("post_reset");
      @(posedge clock); #1;

      for (int k = 0; k < 8; k++) begin
         send16(tbl[k].a, tbl[k].b, tbl[k].cin, tbl[k].exp, 1);
         drain16();
      end

      // Backpressure: result must hold while out_ready stays low.
      i16.out_ready = 1'b0;
      send16(16'hD7D7, 16'h7D7D, 1'b0, 17'h15554, 1);
      n = 0;
      @(negedge clock);
      while (!i16.out_valid && n < 20) begin @(negedge clock); n++; end
      if (!i16.out_valid) fail_now("bp_out_valid");
      for (int k = 0; k < 10; k++) begin
         check("bp_hold_valid",    32'(i16.out_valid), 1);
         check("bp_hold_sum",      32'(i16.sum),       32'h5554);
         check("bp_hold_cout",     32'(i16.cout),      1);
         check("bp_hold_in_ready", 32'(i16.in_ready),  0);
         @(negedge clock);
      end
      @(posedge clock); #1 i16.out_ready = 1'b1;
      @(negedge clock);
      check("bp_hs_in_ready", 32'(i16.in_ready), 0);
      @(negedge clock);
      check("bp_after_in_ready",  32'(i16.in_ready),  1);
      check("bp_after_out_valid", 32'(i16.out_valid), 0);
      @(posedge clock); #1;

      // Reset mid-RUN discards the in-flight operation.
      send16(16'hAAAA, 16'h5555, 1'b0, 17'h0FFFF, 0);
      @(posedge clock); @(posedge clock); #1 reset_n = 1'b0;
      @(negedge clock);
      check_idle("mid_reset");
      @(posedge clock); #1 reset_n = 1'b1;
      @(negedge clock);
      check_idle("after_mid_reset");
      @(posedge clock); #1;
      send16(16'h0003, 16'h0004, 1'b0, 17'h00007, 1);
      drain16();

      have16 = 0; sp_chk = 1;
      for (int k = 0; k < 1000; k++) begin
         ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom_range(0, 1));
         send16(ra, rb, rc, 17'(ra) + 17'(rb) + 17'(rc), 1);
      end
      drain16();
      sp_chk = 0;

      have8 = 0; sp_chk = 1;
      for (int k = 0; k < 1000; k++) begin
         sa = 8'($urandom); sb = 8'($urandom); rc = 1'($urandom_range(0, 1));
         send8(sa, sb, rc, 9'(sa) + 9'(sb) + 9'(rc));
      end
      drain8();
      sp_chk = 0;

      repeat (2) @(posedge clock);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
